// File: rtl/sa_autosa_pdp_rdma_pkg.sv
// rtl/sa_autosa_pdp_rdma_pkg.sv - shared widths, flag positions and FSM states for the PDP RDMA egress
package sa_autosa_pdp_rdma_pkg;

  localparam int PD_W         = 78;
  localparam int DATA_W       = 64;
  localparam int LINE_END_BIT = 72;
  localparam int SURF_END_BIT = 73;
  localparam int CUBE_END_BIT = 77;
  localparam int WIDTH_W      = 13;
  localparam int HEIGHT_W     = 13;
  localparam int SURF_W       = 10;
  localparam int BEAT_W       = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Reserved pd bits stay zero.
  function automatic logic [PD_W-1:0] pack_pd(input logic [DATA_W-1:0] data,
                                              input logic line_end,
                                              input logic surface_end,
                                              input logic cube_end);
    logic [PD_W-1:0] pd;
    pd               = '0;
    pd[DATA_W-1:0]   = data;
    pd[LINE_END_BIT] = line_end;
    pd[SURF_END_BIT] = surface_end;
    pd[CUBE_END_BIT] = cube_end;
    return pd;
  endfunction

endpackage

// File: rtl/sa_autosa_pdp_rdma_eg_pipe.sv
// rtl/sa_autosa_pdp_rdma_eg_pipe.sv - single-entry valid/ready output register
// Accepts a new word whenever empty or being drained in the same cycle.
module sa_autosa_pdp_rdma_eg_pipe
  import sa_autosa_pdp_rdma_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  input  logic [PD_W-1:0] in_pd_i,
  output logic            in_ready_o,
  output logic [PD_W-1:0] out_pd_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);

  logic            valid_q, valid_d;
  logic [PD_W-1:0] pd_q, pd_d;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_pd_o    = pd_q;
  assign out_valid_o = valid_q;

  always_comb begin
    valid_d = valid_q;
    pd_d    = pd_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      pd_d    = in_pd_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pd_q    <= pd_d;
    end
  end

endmodule

// File: rtl/sa_autosa_pdp_rdma_eg.sv
// rtl/sa_autosa_pdp_rdma_eg.sv - PDP RDMA egress: tags read atoms with line/surface/cube ends
// Layer sequencing FSM, position counters and beat accounting around one output register.
module sa_autosa_pdp_rdma_eg
  import sa_autosa_pdp_rdma_pkg::*;
(
  input  logic                autosa_core_clk,
  input  logic                autosa_core_rst,
  input  logic                reg2dp_op_en,
  input  logic [WIDTH_W-1:0]  reg2dp_cube_in_width,
  input  logic [HEIGHT_W-1:0] reg2dp_cube_in_height,
  input  logic [SURF_W-1:0]   reg2dp_cube_in_surface,
  input  logic [DATA_W-1:0]   dma_rd_rsp_pd,
  input  logic                dma_rd_rsp_valid,
  output logic                dma_rd_rsp_ready,
  output logic [PD_W-1:0]     pdp_rdma2dp_pd,
  output logic                pdp_rdma2dp_valid,
  input  logic                pdp_rdma2dp_ready,
  output logic                rdma2reg_done,
  output logic [BEAT_W-1:0]   rdma2reg_beat_num
);

  state_e              state_q, state_d;
  logic                op_en_q;
  logic [WIDTH_W-1:0]  width_q, w_cnt_q, w_cnt_d;
  logic [HEIGHT_W-1:0] height_q, h_cnt_q, h_cnt_d;
  logic [SURF_W-1:0]   surface_q, s_cnt_q, s_cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, beat_num_q, beat_num_d;
  logic                done_q, done_d;

  logic start, in_valid, in_ready, accept, out_hs;
  logic line_end, surface_end, cube_end;

  // Edges are only honoured from IDLE; edges during a layer are dropped, not queued.
  assign start       = (state_q == ST_IDLE) & reg2dp_op_en & ~op_en_q;
  assign in_valid    = dma_rd_rsp_valid & (state_q == ST_RUN);
  assign accept      = in_valid & in_ready;
  assign out_hs      = pdp_rdma2dp_valid & pdp_rdma2dp_ready;

  assign line_end    = (w_cnt_q == width_q);
  assign surface_end = line_end & (h_cnt_q == height_q);
  assign cube_end    = surface_end & (s_cnt_q == surface_q);

  assign dma_rd_rsp_ready  = (state_q == ST_RUN) & in_ready;
  assign rdma2reg_done     = done_q;
  assign rdma2reg_beat_num = beat_num_q;

  sa_autosa_pdp_rdma_eg_pipe u_pipe (
    .clk_i       (autosa_core_clk),
    .rst_i       (autosa_core_rst),
    .in_valid_i  (in_valid),
    .in_pd_i     (pack_pd(dma_rd_rsp_pd, line_end, surface_end, cube_end)),
    .in_ready_o  (in_ready),
    .out_pd_o    (pdp_rdma2dp_pd),
    .out_valid_o (pdp_rdma2dp_valid),
    .out_ready_i (pdp_rdma2dp_ready)
  );

  always_comb begin
    state_d    = state_q;
    w_cnt_d    = w_cnt_q;
    h_cnt_d    = h_cnt_q;
    s_cnt_d    = s_cnt_q;
    beat_d     = beat_q;
    beat_num_d = beat_num_q;
    done_d     = 1'b0;

    if (out_hs) begin
      beat_d = beat_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          w_cnt_d = '0;
          h_cnt_d = '0;
          s_cnt_d = '0;
          beat_d  = '0;
        end
      end
      ST_RUN: begin
        if (accept && cube_end) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Only the cube_end atom can be held here, so this handshake closes the layer.
        if (out_hs) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          beat_num_d = beat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      if (line_end) begin
        w_cnt_d = '0;
        if (h_cnt_q == height_q) begin
          h_cnt_d = '0;
          s_cnt_d = s_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end else begin
        w_cnt_d = w_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      state_q    <= ST_IDLE;
      op_en_q    <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      surface_q  <= '0;
      w_cnt_q    <= '0;
      h_cnt_q    <= '0;
      s_cnt_q    <= '0;
      beat_q     <= '0;
      beat_num_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_en_q    <= reg2dp_op_en;
      w_cnt_q    <= w_cnt_d;
      h_cnt_q    <= h_cnt_d;
      s_cnt_q    <= s_cnt_d;
      beat_q     <= beat_d;
      beat_num_q <= beat_num_d;
      done_q     <= done_d;
      if (start) begin
        width_q   <= reg2dp_cube_in_width;
        height_q  <= reg2dp_cube_in_height;
        surface_q <= reg2dp_cube_in_surface;
      end
    end
  end

endmodule

// File: tb/tb_sa_autosa_pdp_rdma_eg.sv
// tb/tb_sa_autosa_pdp_rdma_eg.sv - directed vector bench for the PDP RDMA egress
module tb_sa_autosa_pdp_rdma_eg;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_en;
  logic [12:0] w, h;
  logic [9:0]  s;
  logic [63:0] rsp_pd;
  logic        rsp_valid, rsp_ready;
  logic [77:0] out_pd;
  logic        out_valid, out_ready;
  logic        done;
  logic [31:0] beat_num;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sa_autosa_pdp_rdma_eg dut (
    .autosa_core_clk        (clk),
    .autosa_core_rst        (rst),
    .reg2dp_op_en           (op_en),
    .reg2dp_cube_in_width   (w),
    .reg2dp_cube_in_height  (h),
    .reg2dp_cube_in_surface (s),
    .dma_rd_rsp_pd          (rsp_pd),
    .dma_rd_rsp_valid       (rsp_valid),
    .dma_rd_rsp_ready       (rsp_ready),
    .pdp_rdma2dp_pd         (out_pd),
    .pdp_rdma2dp_valid      (out_valid),
    .pdp_rdma2dp_ready      (out_ready),
    .rdma2reg_done          (done),
    .rdma2reg_beat_num      (beat_num)
  );

  typedef struct {
    logic [12:0] w;
    logic [12:0] h;
    logic [9:0]  s;
    int          n;
    logic [15:0] line_m;
    logic [15:0] surf_m;
    bit          bp;
    bit          poke;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] data_of(input int idx, input int beat);
    return 64'hA5A5_0000_0000_0000 | (64'(idx) << 32) | 64'(beat);
  endfunction

  task automatic run_layer(input int idx, input bit start, input logic [31:0] prev_num);
    vec_t        v;
    int          sent, got, cyc;
    bit          stall, want_done, done_seen;
    logic [77:0] held, e;
    v = vecs[idx];
    sent = 0; got = 0; cyc = 0;
    stall = 0; want_done = 0; done_seen = 0;
    held = '0;
    if (start) begin
      op_en = 1'b0;
      w = v.w; h = v.h; s = v.s;
      @(negedge clk);
      op_en = 1'b1;
      @(negedge clk);
    end
    while (!done_seen && cyc < 2000) begin
      cyc++;
      out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rsp_valid = (sent < v.n);
      rsp_pd    = data_of(idx, sent);
      if (v.poke) begin
        if (cyc == 3) op_en = 1'b0;
        if (cyc == 4) begin w = 13'd5; h = 13'd0; s = 10'd0; end
        if (cyc == 5) op_en = 1'b1;
      end
      #1;
      if (want_done) begin
        chk("done_pulse", done, 1'b1);
        chk("beat_num_final", beat_num, v.n);
        done_seen = 1;
      end else begin
        chk("no_early_done", done, 1'b0);
        chk("beat_num_hold", beat_num, prev_num);
      end
      if (stall) chk("stall_stable", out_pd, held);
      stall = out_valid & ~out_ready;
      held  = out_pd;
      if (stall) chk("rsp_ready_stalled", rsp_ready, 1'b0);
      if (out_valid && out_pd[77]) chk("drain_rsp_ready", rsp_ready, 1'b0);
      if (out_valid && out_ready) begin
        e = '0;
        e[63:0] = data_of(idx, got);
        if (got < 16) begin
          e[72] = v.line_m[got];
          e[73] = v.surf_m[got];
        end
        e[77] = (got == v.n - 1);
        chk("beat_pd", out_pd, e);
        got++;
        if (got == v.n) want_done = 1;
      end
      if (rsp_valid && rsp_ready) sent++;
      @(negedge clk);
    end
    if (!done_seen) chk("done_timeout", 1'b0, 1'b1);
    chk("beat_count", got, v.n);
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("idle_done", done, 1'b0);
      chk("idle_rsp_ready", rsp_ready, 1'b0);
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_beat_num", beat_num, v.n);
      @(negedge clk);
    end
    rsp_valid = 1'b0;
  endtask

  initial begin
    int sent, cyc;
    vecs[0] = '{13'd3,  13'd1, 10'd0, 8,  16'h0088, 16'h0080, 1'b0, 1'b0};
    vecs[1] = '{13'd0,  13'd0, 10'd0, 1,  16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[2] = '{13'd3,  13'd1, 10'd0, 8,  16'h0088, 16'h0080, 1'b1, 1'b0};
    vecs[3] = '{13'd1,  13'd1, 10'd2, 12, 16'h0AAA, 16'h0888, 1'b0, 1'b1};
    vecs[4] = '{13'd0,  13'd2, 10'd1, 6,  16'h003F, 16'h0024, 1'b1, 1'b0};
    vecs[5] = '{13'd2,  13'd0, 10'd1, 6,  16'h0024, 16'h0024, 1'b0, 1'b1};
    vecs[6] = '{13'd15, 13'd0, 10'd0, 16, 16'h8000, 16'h8000, 1'b1, 1'b1};

    rst = 1'b1; op_en = 1'b0; w = '0; h = '0; s = '0;
    rsp_pd = '0; rsp_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pd", out_pd, 78'd0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_beat_num", beat_num, 32'd0);
    rst = 1'b0; rsp_valid = 1'b0;
    @(negedge clk);

    run_layer(0, 1'b1, 32'd0);
    run_layer(1, 1'b1, 32'd8);
    run_layer(2, 1'b1, 32'd1);
    run_layer(3, 1'b1, 32'd8);
    run_layer(4, 1'b1, 32'd12);
    run_layer(5, 1'b1, 32'd6);

    // Reset after 5 of 16 atoms with op_en held high through release.
    op_en = 1'b0; w = 13'd15; h = 13'd0; s = 10'd0;
    @(negedge clk);
    op_en = 1'b1;
    @(negedge clk);
    sent = 0; cyc = 0;
    while (sent < 5 && cyc < 100) begin
      rsp_valid = 1'b1;
      rsp_pd    = data_of(9, sent);
      out_ready = 1'b1;
      #1;
      if (rsp_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    chk("pre_reset_accepts", sent, 5);
    rsp_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_pd", out_pd, 78'd0);
    chk("midrst_rsp_ready", rsp_ready, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_beat_num", beat_num, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_no_done", done, 1'b0);
    run_layer(6, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_autosa_pdp_rdma_eg.md
SA_AUTOSA_PDP_RDMA_EG -- requirements
Module: sa_autosa_pdp_rdma_eg

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be, in order:
- autosa_core_clk  in  1  core clock.
- autosa_core_rst  in  1  synchronous active-high reset.
- reg2dp_op_en  in  1  layer enable; a rising edge starts a layer.
- reg2dp_cube_in_width  in  13  atoms per line minus 1.
- reg2dp_cube_in_height  in  13  lines per surface minus 1.
- reg2dp_cube_in_surface  in  10  surfaces per cube minus 1.
- dma_rd_rsp_pd  in  64  read-response data atom.
- dma_rd_rsp_valid  in  1  response valid.
- dma_rd_rsp_ready  out  1  response ready.
- pdp_rdma2dp_pd  out  78  atom plus info, sent to the PDP core.
- pdp_rdma2dp_valid  out  1  output valid.
- pdp_rdma2dp_ready  in  1  core ready.
- rdma2reg_done  out  1  one-cycle layer-done pulse.
- rdma2reg_beat_num  out  32  atoms sent in the last completed layer.

Function
REQ-003 pdp_rdma2dp_pd SHALL be laid out as follows:
- [63:0] data.
- [71:64] 0.
- [72] line_end.
- [73] surface_end.
- [76:74] 0.
- [77] cube_end.
REQ-004 Flags SHALL follow these rules:
- line_end = (w_cnt==width).
- surface_end = line_end & (h_cnt==height).
- cube_end = surface_end & (s_cnt==surface).
- Consequence: cube_end always implies surface_end.
REQ-005 The FSM SHALL have states IDLE, RUN and DRAIN, with transitions:
- IDLE->RUN on a reg2dp_op_en rising edge.
- RUN->DRAIN when the cube_end atom is loaded into the output register.
- DRAIN->IDLE on that atom's output handshake.
REQ-006 On entry to RUN, width, height and surface SHALL be latched; w_cnt, h_cnt, s_cnt and the beat counter SHALL be cleared. Later register changes SHALL have no effect during the layer.
REQ-007 dma_rd_rsp_ready SHALL equal (state==RUN) & (~pdp_rdma2dp_valid | pdp_rdma2dp_ready); it is 0 in IDLE and DRAIN.
REQ-008 An input accept (valid & ready) SHALL load {flags, data} into the output register at the next edge (latency 1). Throughput SHALL be one atom per cycle under continuous ready.
REQ-009 While pdp_rdma2dp_valid & ~pdp_rdma2dp_ready, pd and valid SHALL hold stable. Valid SHALL drop after a handshake only if no new atom was accepted in the same cycle.
REQ-010 Counter update on each accept:
- w_cnt increments and wraps to 0 at width.
- On wrap, h_cnt increments and wraps to 0 at height.
- On h wrap, s_cnt increments.
- A single-atom cube (all limits 0) has all three flags set on beat 0.
REQ-011 The 32-bit beat counter SHALL increment on each output handshake and wrap modulo 2^32.
REQ-012 The cycle after the cube_end output handshake SHALL do all of the following:
- Pulse rdma2reg_done for exactly one cycle.
- Update rdma2reg_beat_num with the final count, including the cube_end atom.
- Hold rdma2reg_beat_num otherwise.
REQ-013 A reg2dp_op_en rising edge in RUN or DRAIN SHALL be ignored; it is not queued. A level-high op_en after returning to IDLE SHALL NOT restart the block.
REQ-014 Deasserting reg2dp_op_en mid-layer SHALL NOT abort the layer.

Reset
REQ-015 Reset SHALL put the block in the following state:
- state=IDLE.
- pdp_rdma2dp_valid=0, pdp_rdma2dp_pd=0.
- dma_rd_rsp_ready=0.
- rdma2reg_done=0, rdma2reg_beat_num=0.
- All counters 0.
- op_en edge-detector register = 0.
REQ-016 Reset mid-layer SHALL discard any held atom with no done pulse. op_en already high at reset release SHALL count as a rising edge on the first post-reset cycle.

Structure
REQ-017 A shared package sa_autosa_pdp_rdma_pkg SHALL hold the following:
- PD width (78) and data width (64).
- Flag bit indices (72, 73, 77).
- Config field widths.
- The FSM state enum.
REQ-018 The valid/ready output register SHALL be one sub-module, sa_autosa_pdp_rdma_eg_pipe. Counters, flags and the FSM SHALL stay in the top level.

Verification
REQ-019 Basic layer:
- Stimulus: width=3, height=1, surface=0, 8 atoms, ready always 1.
- Required response: line_end on beats 3 and 7; surface_end and cube_end on beat 7; done one cycle after beat 7; beat_num=8.
REQ-020 Single atom:
- Stimulus: all limits 0.
- Required response: beat 0 has pd[77]=pd[73]=pd[72]=1; state passes through DRAIN; beat_num=1.
REQ-021 Backpressure:
- Stimulus: ready toggles 1010 randomly.
- Required response: pd stable while stalled; no loss or duplication; dma_rd_rsp_ready=0 whenever the output is valid and ready=0.
REQ-022 Op_en edges during a layer:
- Stimulus: a second op_en edge during RUN.
- Required response: ignored; after done with op_en held high, the block stays IDLE; toggling op_en low then high starts a new layer.
REQ-023 Mid-layer reset:
- Stimulus: reset asserted after 5 of 16 atoms.
- Required response: all outputs 0 the next cycle; no done pulse; a new layer then counts from 0.
REQ-024 Multi-surface:
- Stimulus: width=1, height=1, surface=2.
- Required response: surface_end on beats 3, 7 and 11; cube_end only on beat 11.
